// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions,
// the active-high hex glyph table and the per-slot scan state type.
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Entry n lights the segments of hex digit n, bit order {g,f,e,d,c,b,a}
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic {
        BLANK,
        SHOW
    } scan_state_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high segment pattern decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with blanking, digit masking and frame snapshots.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS       = 8,
    parameter int REFRESH_DIV      = 100000,
    parameter int BLANK_CYCLES     = 16,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 1,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              cathode,
    output logic                    dp_out,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_tick
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] LAST_P  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_P = PW'(BLANK_CYCLES);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW != 0}};
    localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW != 0}};
    localparam logic DP_OFF = (SEG_ACTIVE_LOW != 0);

    logic [PW-1:0]                 p_q, p_d;
    scan_state_e                   state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic                          active_q, active_d;
    logic                          pend_q, pend_d;
    logic [NUM_DIGITS-1:0][3:0]    shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0]         shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]         anode_q, anode_d;
    logic [6:0]                    cathode_q, cathode_d;
    logic                          dp_out_q, dp_out_d;
    logic [IDX_W-1:0]              digit_idx_q;
    logic                          frame_tick_q;

    logic                          frame_start;
    logic                          any_en;
    logic                          above_found;
    logic [IDX_W-1:0]              low_idx, above_idx;
    logic                          show;
    logic                          lz_blank;
    logic [NUM_DIGITS-1:0]         anode_on;
    logic [6:0]                    seg_on;
    logic                          dp_on;
    logic [3:0]                    cur_nibble;
    logic [6:0]                    dec_seg;

    // Lowest enabled digit, and the nearest enabled digit above the current one
    always_comb begin
        any_en      = |digit_en;
        low_idx     = '0;
        above_idx   = '0;
        above_found = 1'b0;
        for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
            if (digit_en[j]) begin
                low_idx = IDX_W'(j);
                if (j > int'(idx_q)) begin
                    above_idx   = IDX_W'(j);
                    above_found = 1'b1;
                end
            end
        end
    end

    // pend_q marks the first slot after reset, which always starts a frame
    always_comb begin
        p_d           = (p_q == LAST_P) ? '0 : p_q + 1'b1;
        idx_d         = idx_q;
        active_d      = active_q;
        pend_d        = 1'b0;
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        frame_start   = 1'b0;
        if (pend_q || (p_q == LAST_P)) begin
            active_d = any_en;
            if (any_en) begin
                idx_d = (above_found && !pend_q) ? above_idx : low_idx;
                if (idx_d == low_idx) begin
                    frame_start   = 1'b1;
                    shadow_data_d = digit_data;
                    shadow_dp_d   = dp;
                end
            end
        end
        state_d = (p_d < BLANK_P) ? BLANK : SHOW;
    end

    assign cur_nibble = shadow_data_q[idx_q];

    seg7_hex_decode u_decode (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    always_comb begin
        lz_blank = (idx_q != '0);
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((j >= int'(idx_q)) && ((j == int'(idx_q)) || digit_en[j]) &&
                (shadow_data_q[j] != 4'h0))
                lz_blank = 1'b0;
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        show     = (state_q == SHOW) && active_q;
        anode_on = '0;
        seg_on   = '0;
        dp_on    = 1'b0;
        if (show) begin
            anode_on[idx_q] = 1'b1;
            if (!lz_blank)
                seg_on = dec_seg;
            dp_on = shadow_dp_q[idx_q];
        end
        anode_d   = (ANODE_ACTIVE_LOW != 0) ? ~anode_on : anode_on;
        cathode_d = (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
        dp_out_d  = (SEG_ACTIVE_LOW != 0) ? ~dp_on : dp_on;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q           <= '0;
            state_q       <= BLANK;
            idx_q         <= '0;
            active_q      <= 1'b0;
            pend_q        <= 1'b1;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            anode_q       <= ANODE_OFF;
            cathode_q     <= SEG_OFF;
            dp_out_q      <= DP_OFF;
            digit_idx_q   <= '0;
            frame_tick_q  <= 1'b0;
        end else begin
            p_q           <= p_d;
            state_q       <= state_d;
            idx_q         <= idx_d;
            active_q      <= active_d;
            pend_q        <= pend_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            anode_q       <= anode_d;
            cathode_q     <= cathode_d;
            dp_out_q      <= dp_out_d;
            digit_idx_q   <= idx_q;
            frame_tick_q  <= frame_start;
        end
    end

    assign anode      = anode_q;
    assign cathode    = cathode_q;
    assign dp_out     = dp_out_q;
    assign digit_idx  = digit_idx_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multiplexed seven-segment display driver: time-slices NUM_DIGITS common-anode digits from one clock, decodes a per-digit hex nibble to segments, and inserts a blanking interval between digits to suppress ghosting. Supersedes the fixed 8-anode refresh-counter decoder. It sits between the counter/datapath logic and the board's anode/cathode pins, and adds digit-enable masking, tear-free frame snapshots and a frame strobe.

## Interface
- NUM_DIGITS, 8: number of digits/anodes; 1..16.
- REFRESH_DIV, 100000: clock cycles per digit slot; must exceed BLANK_CYCLES.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes and segments off; 0 disables blanking.
- ANODE_ACTIVE_LOW, 1: 1 means an anode is on when 0.
- SEG_ACTIVE_LOW, 1: 1 means a segment or dp is lit when 0.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- digit_data  in  4*NUM_DIGITS  hex nibble per digit; nibble i = bits [4i+3:4i]; digit 0 is least significant.
- dp  in  NUM_DIGITS  decimal point request per digit.
- digit_en  in  NUM_DIGITS  scan mask; disabled digits are skipped entirely.
- anode  out  NUM_DIGITS  anode drive, polarity per ANODE_ACTIVE_LOW.
- cathode  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- dp_out  out  1  decimal-point cathode.
- digit_idx  out  clog2(NUM_DIGITS), min 1  index of the digit owning the current slot.
- frame_tick  out  1  one-cycle pulse when a new frame snapshot is taken.

## Operation
- Prescaler p counts 0..REFRESH_DIV-1 and wraps; each wrap is a slot boundary.
- Two-state FSM per slot: BLANK while p < BLANK_CYCLES, then SHOW for the rest of the slot. In BLANK, all anodes, segments and dp_out are inactive. In SHOW, only anode[digit_idx] is active, and cathode/dp_out show that digit.
- At each slot boundary, digit_idx advances to the next enabled digit in ascending order and wraps past NUM_DIGITS-1. digit_en is sampled live at each boundary.
- Frame start: a boundary at which the selected index is the lowest enabled digit (a wrap, or the first slot after reset). On the same edge, digit_data and dp are copied into a shadow register and frame_tick pulses. Decoding uses only the shadow register, so no frame ever mixes old and new data.
- If digit_en == 0 at a boundary: digit_idx is held, outputs stay inactive for the whole slot, frame_tick does not pulse, and the prescaler keeps running. Scanning resumes at the next boundary after any bit is set.
- Decode uses the standard hex map for 0-9 and A, b, C, d, E, F.
- Reset in any state: on the next edge, p=0, FSM=BLANK, digit_idx=0, shadow=0, and all outputs take their reset values. The first slot after reset belongs to the lowest enabled digit and is a frame start.

## Timing
- Reset values: anode all inactive (all 1s when ANODE_ACTIVE_LOW), cathode all off (7'h7F when SEG_ACTIVE_LOW), dp_out off, digit_idx=0, frame_tick=0.
- All outputs are registered and change only on clk edges.
- After reset falls, the first anode asserts BLANK_CYCLES+1 edges later. It stays asserted for REFRESH_DIV-BLANK_CYCLES cycles, followed by BLANK_CYCLES cycles with everything off.
- frame_tick period = REFRESH_DIV × number of enabled digits.
- Changes to digit_data take effect at the next frame_tick. The worst-case latency is one frame plus one cycle.

## Configuration
- SEG7_LEADING_ZERO_BLANK_EN defined: digit i > 0 shows all segments off when its shadow nibble and every higher enabled digit's nibble are 0. Its anode still pulses and its dp is still shown. Digit 0 is never blanked.
- Undefined: every enabled digit shows its nibble, including zeros.

## Structure
- Package seg7_pkg contains:
  - the segment bit-order constants;
  - the 16-entry hex-to-segment constant table (active-high);
  - the FSM state typedef (BLANK, SHOW).
- Sub-module seg7_hex_decode: a combinational nibble-to-segments decoder. Polarity is applied in the top level.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, and active-low anodes and segments.
- Reset held, then released: anode=4'b1111, cathode=7'h7F, dp_out=1, frame_tick=0 until the first slot.
- digit_data=16'h1234, digit_en=4'hF: anode cycles 1110, 1101, 1011, 0111. Each is low for 6 cycles, separated by 2 cycles of 1111. Cathode is 7'h19 ("4") during 1110 and 7'h79 ("1") during 0111. frame_tick pulses every 32 cycles.
- digit_en=4'b0101: only digits 0 and 2 are scanned, frame_tick pulses every 16 cycles, and anode never shows 1101 or 0111. Setting digit_en=0 gives anode=4'b1111 and no frame_tick.
- digit_data changed from 16'h1234 to 16'hABCD mid-frame: the remaining slots of that frame still show 3, 2, 1. The next frame shows D (7'h21) on digit 0.
- digit_data=16'h0050, dp=4'b0010:
  - With SEG7_LEADING_ZERO_BLANK_EN: digits 3 and 2 show cathode 7'h7F with their anodes still pulsing, digit 1 shows 7'h12 with dp_out=0, digit 0 shows 7'h40.
  - Without the macro: digit 3 shows 7'h40.
- reset asserted during a SHOW slot of digit 2: on the next edge the outputs return to their reset values, and scanning restarts at digit 0 with frame_tick.
